stall_ctrl: RTL and testbench

Hazard and stall controller for the five-stage MIPS pipeline. It compares the source registers of the instruction in ID against the destinations in flight in EX and MEM, using Tuse/Tnew. It also tracks the multiply/divide unit's busy interval with an internal counter. Its outputs drive the PC enable, the IF/ID enable, and the bubble insertion into the ID/EX pipeline register, which has a synchronous clear.

---
 rtl/stall_ctrl.sv | 95 +++++++++
 tb/tb_stall_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew RAW detection plus mult/div busy tracking.
// Define STALL_CNT_EN to add the 32-bit stall_cnt performance counter.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic       md_use_D,
    input  logic [4:0] regWA_E,
    input  logic       RegWrite_E,
    input  logic [1:0] Tnew_E,
    input  logic [4:0] regWA_M,
    input  logic       RegWrite_M,
    input  logic [1:0] Tnew_M,
    input  logic       md_start_E,
    input  logic       md_div_E,
    output logic       stall,
    output logic       en_pc,
    output logic       en_fd,
    output logic       flush_de,
    output logic       md_busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz_rs, haz_rt, haz_md;

    // Tuse of 3 can never be below a 2-bit Tnew, so unused sources drop out.
    function automatic logic raw(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       we,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && we && (wa == src) && (tuse < tnew);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (md_start_E) begin
            cnt_d = md_div_E ? DIV_LD : MULT_LD;
        end
    end

    always_comb begin
        md_busy  = (cnt_q != '0);
        haz_rs   = raw(rs_D, Tuse_rs_D, RegWrite_E, regWA_E, Tnew_E)
                 | raw(rs_D, Tuse_rs_D, RegWrite_M, regWA_M, Tnew_M);
        haz_rt   = raw(rt_D, Tuse_rt_D, RegWrite_E, regWA_E, Tnew_E)
                 | raw(rt_D, Tuse_rt_D, RegWrite_M, regWA_M, Tnew_M);
        haz_md   = md_use_D & (md_busy | md_start_E);
        stall    = ~reset & (haz_rs | haz_rt | haz_md);
        en_pc    = ~stall;
        en_fd    = ~stall;
        flush_de = stall;
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl.
// Counter checks run only when STALL_CNT_EN is defined.
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, regWA_E, regWA_M;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
    logic       md_use_D, RegWrite_E, RegWrite_M, md_start_E, md_div_E;
    logic       stall, en_pc, en_fd, flush_de, md_busy;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .Tuse_rs_D  (Tuse_rs_D),
        .Tuse_rt_D  (Tuse_rt_D),
        .md_use_D   (md_use_D),
        .regWA_E    (regWA_E),
        .RegWrite_E (RegWrite_E),
        .Tnew_E     (Tnew_E),
        .regWA_M    (regWA_M),
        .RegWrite_M (RegWrite_M),
        .Tnew_M     (Tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall),
        .en_pc      (en_pc),
        .en_fd      (en_fd),
        .flush_de   (flush_de),
        .md_busy    (md_busy)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs_D = 0; rt_D = 0; Tuse_rs_D = 3; Tuse_rt_D = 3;
        md_use_D = 0; regWA_E = 0; RegWrite_E = 0; Tnew_E = 0;
        regWA_M = 0; RegWrite_M = 0; Tnew_M = 0;
        md_start_E = 0; md_div_E = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr();
        reset = 1;
        // hazard present while in reset must be masked
        rs_D = 8; Tuse_rs_D = 1; regWA_E = 8; RegWrite_E = 1; Tnew_E = 2;
        tick();
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_en_pc", {31'd0, en_pc}, 1);
        chk("rst_en_fd", {31'd0, en_fd}, 1);
        chk("rst_flush", {31'd0, flush_de}, 0);
        chk("rst_md_busy", {31'd0, md_busy}, 0);

        reset = 0;
        #1;
        chk("ex_raw_stall", {31'd0, stall}, 1);
        chk("ex_raw_flush", {31'd0, flush_de}, 1);
        chk("ex_raw_en_pc", {31'd0, en_pc}, 0);
        chk("ex_raw_en_fd", {31'd0, en_fd}, 0);
        Tnew_E = 1;
        #1;
        chk("ex_tnew1", {31'd0, stall}, 0);

        clr();
        regWA_E = 0; RegWrite_E = 1; Tnew_E = 2; rs_D = 0; Tuse_rs_D = 0;
        #1;
        chk("reg0", {31'd0, stall}, 0);

        clr();
        regWA_M = 9; RegWrite_M = 1; Tnew_M = 1; rt_D = 9; Tuse_rt_D = 0;
        #1;
        chk("mem_rt", {31'd0, stall}, 1);
        Tuse_rt_D = 3;
        #1;
        chk("mem_rt_unused", {31'd0, stall}, 0);
        Tuse_rt_D = 0; RegWrite_M = 0;
        #1;
        chk("mem_nowrite", {31'd0, stall}, 0);

        clr();
        rs_D = 12; Tuse_rs_D = 0;
        regWA_E = 12; RegWrite_E = 1; Tnew_E = 2;
        regWA_M = 12; RegWrite_M = 1; Tnew_M = 1;
        #1;
        chk("ex_mem_same", {31'd0, stall}, 1);
        RegWrite_E = 0;
        regWA_M = 13;
        #1;
        chk("other_reg", {31'd0, stall}, 0);

        // div: cycle 0 start, busy cycles 1..10, proceed at 11
        clr();
        tick();
        md_use_D = 1; md_start_E = 1; md_div_E = 1;
        #1;
        chk("div_c0_stall", {31'd0, stall}, 1);
        chk("div_c0_busy", {31'd0, md_busy}, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            md_start_E = 0; md_div_E = 0;
            #1;
            chk($sformatf("div_c%0d_busy", c), {31'd0, md_busy}, 1);
            chk($sformatf("div_c%0d_stall", c), {31'd0, stall}, 1);
        end
        tick();
        chk("div_c11_busy", {31'd0, md_busy}, 0);
        chk("div_c11_stall", {31'd0, stall}, 0);

        // mult without md consumer in ID: busy but no stall
        clr();
        md_start_E = 1;
        tick();
        md_start_E = 0;
        #1;
        chk("mult_c1_busy", {31'd0, md_busy}, 1);
        chk("mult_nouse", {31'd0, stall}, 0);
        for (int c = 2; c <= 5; c++) tick();
        chk("mult_c5_busy", {31'd0, md_busy}, 1);
        tick();
        chk("mult_c6_busy", {31'd0, md_busy}, 0);

        // reset during the 3rd busy cycle of a mult, mfhi pending
        clr();
        md_use_D = 1; md_start_E = 1;
        tick();
        md_start_E = 0;
        tick();
        tick();
        #1;
        chk("mult_c3_stall", {31'd0, stall}, 1);
        reset = 1;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 0);
        tick();
        reset = 0;
        #1;
        chk("post_rst_busy", {31'd0, md_busy}, 0);
        chk("post_rst_stall", {31'd0, stall}, 0);

`ifdef STALL_CNT_EN
        clr();
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("cnt_reset", stall_cnt, 0);
        rs_D = 8; Tuse_rs_D = 1; regWA_E = 8; RegWrite_E = 1; Tnew_E = 2;
        for (int i = 0; i < 7; i++) tick();
        clr();
        #1;
        chk("cnt_seven", stall_cnt, 7);
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        rs_D = 8; Tuse_rs_D = 1; regWA_E = 8; RegWrite_E = 1; Tnew_E = 2;
        tick();
        clr();
        #1;
        chk("cnt_wrap", stall_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
